// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: controller state encoding, default timing
// constants and counter widths, plus the odd-parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQUEST   = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } ps2_state_t;

    // 100 us inhibit and 15 ms inter-edge timeout at a 25 MHz system clock
    localparam int PS2_INHIBIT_CYCLES = 2500;
    localparam int PS2_TIMEOUT_CYCLES = 375000;

    localparam int PS2_CNT_W   = 19;
    localparam int PS2_BIT_W   = 4;
    localparam int PS2_FRAME_W = 11;

    // PS/2 uses odd parity: the parity bit makes the total count of ones odd
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for an asynchronous PS/2 pin plus a falling-edge
// detector on the synchronized level. Flops reset to 1 (idle bus level).
module ps2_sync_edge (
    input  logic clk,
    input  logic nreset,
    input  logic pin,
    output logic level,
    output logic fall
);

    logic [2:0] sync_q;

    // Shift the raw pin through two metastability flops and one history flop
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[1:0], pin};
        end
    end

    assign level = sync_q[1];
    assign fall  = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// shifts out data/parity/stop on device clock falling edges, checks the ACK
// and waits for the bus to return idle. Any stall past the timeout aborts.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       start,
    input  logic [7:0] tx_data,
    output logic       busy,
    output logic       done,
    output logic       err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low
);

    localparam logic [PS2_CNT_W-1:0] INHIBIT_LAST = PS2_CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [PS2_CNT_W-1:0] TIMEOUT_LAST = PS2_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PS2_BIT_W-1:0] LAST_BIT     = PS2_BIT_W'(9);

    ps2_state_t               state, state_n;
    logic [PS2_CNT_W-1:0]     cnt, cnt_n;
    logic [PS2_BIT_W-1:0]     bit_cnt, bit_cnt_n;
    logic [PS2_FRAME_W-1:0]   frame, frame_n;
    logic                     clk_dl_n, data_dl_n, done_n, err_n;
    logic                     clk_level, clk_fall, data_level, data_fall_unused;
    logic                     watched;

    ps2_sync_edge u_sync_clk (
        .clk    (clk),
        .nreset (nreset),
        .pin    (ps2_clk_in),
        .level  (clk_level),
        .fall   (clk_fall)
    );

    ps2_sync_edge u_sync_data (
        .clk    (clk),
        .nreset (nreset),
        .pin    (ps2_data_in),
        .level  (data_level),
        .fall   (data_fall_unused)
    );

    assign busy = (state != ST_IDLE);

    // State, counters, frame and registered line/pulse outputs
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state              <= ST_IDLE;
            cnt                <= '0;
            bit_cnt            <= '0;
            frame              <= '0;
            ps2_clk_drive_low  <= 1'b0;
            ps2_data_drive_low <= 1'b0;
            done               <= 1'b0;
            err                <= 1'b0;
        end else begin
            state              <= state_n;
            cnt                <= cnt_n;
            bit_cnt            <= bit_cnt_n;
            frame              <= frame_n;
            ps2_clk_drive_low  <= clk_dl_n;
            ps2_data_drive_low <= data_dl_n;
            done               <= done_n;
            err                <= err_n;
        end
    end

    // Next-state, counter and line-drive decisions
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_cnt_n = bit_cnt;
        frame_n   = frame;
        clk_dl_n  = ps2_clk_drive_low;
        data_dl_n = ps2_data_drive_low;
        done_n    = 1'b0;
        err_n     = 1'b0;
        watched   = 1'b0;

        case (state)
            ST_IDLE: begin
                clk_dl_n  = 1'b0;
                data_dl_n = 1'b0;
                if (start) begin
                    // frame[0] is the start bit so the shift register supplies every line level
                    frame_n  = {1'b1, odd_parity(tx_data), tx_data, 1'b0};
                    cnt_n    = '0;
                    clk_dl_n = 1'b1;
                    state_n  = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (cnt == INHIBIT_LAST) begin
                    cnt_n     = '0;
                    clk_dl_n  = 1'b0;
                    data_dl_n = ~frame[0];
                    state_n   = ST_REQUEST;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_REQUEST: begin
                watched   = 1'b1;
                cnt_n     = clk_fall ? '0 : cnt + 1'b1;
                bit_cnt_n = '0;
                state_n   = ST_SHIFT;
            end
            ST_SHIFT: begin
                watched = 1'b1;
                cnt_n   = clk_fall ? '0 : cnt + 1'b1;
                if (clk_fall) begin
                    data_dl_n = ~frame[1];
                    frame_n   = {1'b1, frame[PS2_FRAME_W-1:1]};
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state_n = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                watched = 1'b1;
                cnt_n   = clk_fall ? '0 : cnt + 1'b1;
                if (clk_fall) begin
                    data_dl_n = 1'b0;
                    if (!data_level) begin
                        state_n = ST_WAIT_IDLE;
                    end else begin
                        err_n   = 1'b1;
                        state_n = ST_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                watched = 1'b1;
                cnt_n   = clk_fall ? '0 : cnt + 1'b1;
                if (clk_level && data_level) begin
                    done_n  = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: begin
                clk_dl_n  = 1'b0;
                data_dl_n = 1'b0;
                state_n   = ST_IDLE;
            end
        endcase

        // A stalled device aborts the transfer; this wins over any done pulse
        if (watched && !clk_fall && (cnt == TIMEOUT_LAST)) begin
            clk_dl_n  = 1'b0;
            data_dl_n = 1'b0;
            done_n    = 1'b0;
            err_n     = 1'b1;
            cnt_n     = '0;
            state_n   = ST_IDLE;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a behavioural PS/2 device clocks the
// frame out, records the bits it sees, and results are compared with the
// frame expected for the transmitted byte.
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int TMO  = 100;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       busy, done, err;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_drive_low, ps2_data_drive_low;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;

    int n_assert = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    int lines_bad = 0;
    logic err_prev = 1'b0;

    // open-collector bus: either side may pull a line low
    assign ps2_clk_in  = dev_clk  & ~ps2_clk_drive_low;
    assign ps2_data_in = dev_data & ~ps2_data_drive_low;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk                (clk),
        .nreset             (nreset),
        .start              (start),
        .tx_data            (tx_data),
        .busy               (busy),
        .done               (done),
        .err                (err),
        .ps2_clk_in         (ps2_clk_in),
        .ps2_data_in        (ps2_data_in),
        .ps2_clk_drive_low  (ps2_clk_drive_low),
        .ps2_data_drive_low (ps2_data_drive_low)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (done && err) both_cnt++;
        if (err && (ps2_clk_drive_low || ps2_data_drive_low)) lines_bad++;
        if (err_prev && (ps2_clk_drive_low || ps2_data_drive_low)) lines_bad++;
        err_prev = err;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_parity(input logic [7:0] d);
        return ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    endfunction

    task automatic pulse_start(input logic [7:0] d);
        tx_data = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Device side of one host-to-device frame
    task automatic dev_frame(input bit ack, input bit abort, input bit spurious,
                             output logic [9:0] bits, output logic start_bit, output bit ok);
        int t;
        ok = 1'b1;
        bits = '0;
        start_bit = 1'bx;
        t = 0;
        while (!ps2_clk_drive_low && t < 200) begin @(negedge clk); t++; end
        t = 0;
        while (!(!ps2_clk_drive_low && ps2_data_drive_low) && t < 200) begin @(negedge clk); t++; end
        if (ps2_clk_drive_low || !ps2_data_drive_low) begin
            ok = 1'b0;
            return;
        end
        repeat (HALF) @(negedge clk);
        start_bit = ps2_data_in;
        for (int i = 0; i < 10; i++) begin
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            for (int c = 0; c < HALF; c++) begin
                if (c == 2) begin
                    bits[i] = ps2_data_in;
                    if (abort && i == 3) begin
                        nreset = 1'b0;
                        return;
                    end
                end
                if (spurious && i == 2 && c == 3) begin
                    start = 1'b1;
                    tx_data = ~tx_data;
                end
                if (c == 4) start = 1'b0;
                @(negedge clk);
            end
        end
        dev_data = ack ? 1'b0 : 1'b1;
        repeat (4) @(negedge clk);
        dev_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_clk = 1'b1;
        repeat (4) @(negedge clk);
        dev_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_and_check(input string tag, input logic [7:0] d, input bit spurious);
        logic [9:0] bits;
        logic       sb;
        bit         ok;
        int         d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        pulse_start(d);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        dev_frame(1'b1, 1'b0, spurious, bits, sb, ok);
        repeat (10) @(negedge clk);
        check({tag, "_handshake"}, 32'(ok), 32'd1);
        check({tag, "_startbit"}, 32'(sb), 32'd0);
        check({tag, "_byte"}, 32'(bits[7:0]), 32'(d));
        check({tag, "_parity"}, 32'(bits[8]), 32'(exp_parity(d)));
        check({tag, "_stop"}, 32'(bits[9]), 32'd1);
        check({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_err"}, 32'(err_cnt - e0), 32'd0);
        check({tag, "_idle"}, 32'({busy, ps2_clk_drive_low, ps2_data_drive_low}), 32'd0);
    endtask

    initial begin
        logic [9:0] bits;
        logic       sb;
        bit         ok;
        int         n, k, d0, e0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done_err", 32'({done, err}), 32'd0);
        check("rst_lines", 32'({ps2_clk_drive_low, ps2_data_drive_low}), 32'd0);
        nreset = 1'b1;
        repeat (3) @(negedge clk);

        // spurious device clock edges while idle
        d0 = done_cnt; e0 = err_cnt;
        for (int i = 0; i < 3; i++) begin
            dev_clk = 1'b0; repeat (5) @(negedge clk);
            dev_clk = 1'b1; repeat (5) @(negedge clk);
        end
        check("idle_spur", 32'({busy, ps2_clk_drive_low, ps2_data_drive_low}), 32'd0);
        check("idle_spur_pulses", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);

        // directed bytes
        send_and_check("ed", 8'hED, 1'b0);
        send_and_check("x01", 8'h01, 1'b0);
        send_and_check("xff", 8'hFF, 1'b0);

        // missing ACK
        d0 = done_cnt; e0 = err_cnt;
        pulse_start(8'h3C);
        dev_frame(1'b0, 1'b0, 1'b0, bits, sb, ok);
        repeat (5) @(negedge clk);
        check("nack_handshake", 32'(ok), 32'd1);
        check("nack_err", 32'(err_cnt - e0), 32'd1);
        check("nack_done", 32'(done_cnt - d0), 32'd0);
        check("nack_lines", 32'(lines_bad), 32'd0);

        // timeout: device never clocks
        e0 = err_cnt;
        pulse_start(8'hA5);
        n = 0;
        while (ps2_clk_drive_low && n < 1000) begin n++; @(negedge clk); end
        check("inhibit_len", 32'(n), 32'(INH));
        check("request_data_low", 32'(ps2_data_drive_low), 32'd1);
        k = 0;
        while (!err && k < 1000) begin k++; @(negedge clk); end
        check("timeout_len", 32'(k), 32'(TMO));
        check("timeout_lines", 32'({ps2_clk_drive_low, ps2_data_drive_low}), 32'd0);
        repeat (3) @(negedge clk);
        check("timeout_err_cnt", 32'(err_cnt - e0), 32'd1);
        check("timeout_lines_bad", 32'(lines_bad), 32'd0);

        // reset after the 4th data bit, then a normal frame
        pulse_start(8'h96);
        dev_frame(1'b1, 1'b1, 1'b0, bits, sb, ok);
        #1;
        check("abort_lines", 32'({ps2_clk_drive_low, ps2_data_drive_low}), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_bits", 32'(bits[3:0]), 32'(4'h6));
        dev_clk = 1'b1;
        dev_data = 1'b1;
        d0 = done_cnt; e0 = err_cnt;
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        repeat (150) @(negedge clk);
        check("abort_no_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
        send_and_check("after_rst", 8'h96, 1'b0);

        // start during SHIFT with a different byte must be ignored
        send_and_check("spur_start", 8'h4B, 1'b1);

        // random bytes
        for (int r = 0; r < 6; r++) begin
            send_and_check("rand", 8'($urandom), 1'b0);
        end

        check("never_both", 32'(both_cnt), 32'd0);
        check("err_lines_final", 32'(lines_bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 2500, clk cycles ps2 clock is held low before the request (100 us at 25 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 375000, max clk cycles between consecutive device clock falling edges (15 ms at 25 MHz).
REQ-003 The block has one clock, clk; reset is asynchronous and active-low, nreset.
REQ-004 clk  input  1  system clock.
REQ-005 nreset  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle request to send tx_data; sampled only in IDLE.
REQ-007 tx_data  input  8  command byte to device.
REQ-008 busy  output  1  high from the cycle after an accepted start until the cycle done/err pulses.
REQ-009 done  output  1  one-cycle pulse: byte sent and acknowledged.
REQ-010 err  output  1  one-cycle pulse: missing ACK or timeout.
REQ-011 ps2_clk_in  input  1  raw PS/2 clock pin level (asynchronous).
REQ-012 ps2_data_in  input  1  raw PS/2 data pin level (asynchronous).
REQ-013 ps2_clk_drive_low  output  1  open-collector enable; 1 pulls PS2 clock low.
REQ-014 ps2_data_drive_low  output  1  open-collector enable; 1 pulls PS2 data low.

Function
REQ-015 Both pin inputs SHALL pass a 2-FF synchronizer; device clock falling edge = previous synced 1, current synced 0 (detected 3 clk after pin edge).
REQ-016 States: IDLE, INHIBIT, REQUEST, SHIFT, ACK, WAIT_IDLE.
REQ-017 IDLE: both drive-lows 0; start=1 latches frame {stop=1, parity, tx_data} and enters INHIBIT; start while busy is ignored.
REQ-018 Parity SHALL be odd: parity bit = ~^tx_data.
REQ-019 INHIBIT: clk_drive_low=1, data_drive_low=0 for exactly INHIBIT_CYCLES cycles, then REQUEST.
REQ-020 REQUEST: data_drive_low=1 (start bit), clk_drive_low=0 in the same cycle; enter SHIFT, bit counter=0.
REQ-021 SHIFT: on each detected falling edge, data_drive_low = ~frame bit[counter] (LSB first: d0..d7, parity, stop); counter increments; after stop bit (10th edge) go to ACK.
REQ-022 ACK: on next falling edge sample synced data; 0 -> WAIT_IDLE, 1 -> err pulse, IDLE.
REQ-023 WAIT_IDLE: when synced clock and data both 1, pulse done, go IDLE.
REQ-024 Timeout counter SHALL clear on entering REQUEST and on every falling edge; reaching TIMEOUT_CYCLES in REQUEST/SHIFT/ACK/WAIT_IDLE SHALL release both lines, pulse err, go IDLE.
REQ-025 done and err SHALL never pulse in the same cycle; busy=0 in IDLE only.
REQ-026 Spurious falling edges in IDLE/INHIBIT SHALL be ignored.

Reset
REQ-027 nreset low: state IDLE, busy/done/err 0, both drive-lows 0 (lines released), counters 0, synchronizers to 1, within the same asynchronous assertion.
REQ-028 Reset mid-frame SHALL release both lines immediately with no done/err pulse afterwards.

Structure
REQ-029 State encoding and default cycle constants SHALL reside in shared package ps2_pkg, reused by the existing PS/2 receiver.
REQ-030 One sub-module, ps2_sync_edge (2-FF sync plus falling-edge detect), instantiated once for clock and once for data (edge output unused for data).
REQ-031 Counters: 19-bit shared inhibit/timeout counter, 4-bit bit counter, 11-bit frame shift register.

Verification
REQ-032 tx_data=0xED, device model clocks at 12 kHz and ACKs -> data sequence after start bit 1,0,1,1,0,1,1,1, parity 1, stop 1; done pulses once; err 0.
REQ-033 tx_data=0x01 -> parity bit 0; tx_data=0xFF -> parity bit 1; both done.
REQ-034 Device leaves data high at 11th edge -> err pulse, done never, both drive-lows 0 next cycle.
REQ-035 INHIBIT_CYCLES=20, TIMEOUT_CYCLES=100, device never clocks -> clk_drive_low high exactly 20 cycles, err pulses 100 cycles after REQUEST.
REQ-036 nreset asserted after 4th data bit -> both drive-lows 0 same cycle, busy 0; new start after release sends complete frame normally.
REQ-037 start pulsed during SHIFT with different tx_data -> ignored; transmitted byte unchanged.
